// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU definitions: ALU operation codes, opcode/funct/REGIMM constants
// and the decoded-instruction record passed from decode to execute.
package mips_cpu_pkg;

  localparam logic [4:0] ALU_AND  = 5'b00000;
  localparam logic [4:0] ALU_OR   = 5'b00001;
  localparam logic [4:0] ALU_ADDU = 5'b00010;
  localparam logic [4:0] ALU_SUBU = 5'b00110;
  localparam logic [4:0] ALU_SLTU = 5'b00111;
  localparam logic [4:0] ALU_SLT  = 5'b01000;
  localparam logic [4:0] ALU_SLL  = 5'b01001;
  localparam logic [4:0] ALU_SRA  = 5'b01010;
  localparam logic [4:0] ALU_SRL  = 5'b01011;
  localparam logic [4:0] ALU_NOR  = 5'b01100;
  localparam logic [4:0] ALU_XOR  = 5'b01101;
  localparam logic [4:0] ALU_SLLV = 5'b01110;
  localparam logic [4:0] ALU_SRAV = 5'b01111;
  localparam logic [4:0] ALU_SRLV = 5'b10000;
  localparam logic [4:0] ALU_BNE  = 5'b11000;
  localparam logic [4:0] ALU_BGTZ = 5'b11001;
  localparam logic [4:0] ALU_BLEZ = 5'b11010;
  localparam logic [4:0] ALU_BGEZ = 5'b11011;
  localparam logic [4:0] ALU_BLTZ = 5'b11111;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  typedef struct packed {
    logic [4:0]  alu_control;
    logic [4:0]  alu_as;
    logic [31:0] imm_ext;
    logic        alu_src_imm;
    logic        a_zero;
    logic        branch;
    logic        jump;
    logic        link;
    logic        illegal;
  } decoded_t;

endpackage

// File: rtl/mips_cpu_alu_decode_comb.sv
// Pure combinational decode of one MIPS32 instruction word into ALU control fields.
module mips_cpu_alu_decode_comb
  import mips_cpu_pkg::*;
(
  input  logic [31:0] instr_i,
  output decoded_t    dec_o
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [15:0] imm;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic        unused_rs;
  decoded_t    dec;

  assign op        = instr_i[31:26];
  assign rt        = instr_i[20:16];
  assign funct     = instr_i[5:0];
  assign imm       = instr_i[15:0];
  assign imm_sext  = {{16{imm[15]}}, imm};
  assign imm_zext  = {16'h0000, imm};
  assign unused_rs = ^instr_i[25:21];

  always_comb begin
    dec         = '0;
    dec.alu_as  = instr_i[10:6];
    dec.imm_ext = imm_sext;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_AND:  dec.alu_control = ALU_AND;
          FN_OR:   dec.alu_control = ALU_OR;
          FN_ADDU: dec.alu_control = ALU_ADDU;
          FN_SUBU: dec.alu_control = ALU_SUBU;
          FN_SLTU: dec.alu_control = ALU_SLTU;
          FN_SLT:  dec.alu_control = ALU_SLT;
          FN_SLL:  dec.alu_control = ALU_SLL;
          FN_SRA:  dec.alu_control = ALU_SRA;
          FN_SRL:  dec.alu_control = ALU_SRL;
          FN_NOR:  dec.alu_control = ALU_NOR;
          FN_XOR:  dec.alu_control = ALU_XOR;
          FN_SLLV: dec.alu_control = ALU_SLLV;
          FN_SRAV: dec.alu_control = ALU_SRAV;
          FN_SRLV: dec.alu_control = ALU_SRLV;
          FN_JR, FN_JALR: begin
            dec.alu_control = ALU_ADDU;
            dec.jump        = 1'b1;
            dec.link        = (funct == FN_JALR);
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_ADDIU, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: begin
        dec.alu_control = ALU_ADDU;
        dec.alu_src_imm = 1'b1;
      end
      OP_SLTI: begin
        dec.alu_control = ALU_SLT;
        dec.alu_src_imm = 1'b1;
      end
      OP_SLTIU: begin
        dec.alu_control = ALU_SLTU;
        dec.alu_src_imm = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec.alu_control = (op == OP_ANDI) ? ALU_AND : (op == OP_ORI) ? ALU_OR : ALU_XOR;
        dec.imm_ext     = imm_zext;
        dec.alu_src_imm = 1'b1;
      end
      OP_LUI: begin
        // OR against a zeroed operand a places the immediate in the upper half.
        dec.alu_control = ALU_OR;
        dec.imm_ext     = {imm, 16'h0000};
        dec.alu_src_imm = 1'b1;
        dec.a_zero      = 1'b1;
      end
      OP_BEQ:  begin dec.alu_control = ALU_SUBU; dec.branch = 1'b1; end
      OP_BNE:  begin dec.alu_control = ALU_BNE;  dec.branch = 1'b1; end
      OP_BLEZ: begin dec.alu_control = ALU_BLEZ; dec.branch = 1'b1; end
      OP_BGTZ: begin dec.alu_control = ALU_BGTZ; dec.branch = 1'b1; end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BLTZAL: begin
            dec.alu_control = ALU_BLTZ;
            dec.branch      = 1'b1;
            dec.link        = (rt == RT_BLTZAL);
          end
          RT_BGEZ, RT_BGEZAL: begin
            dec.alu_control = ALU_BGEZ;
            dec.branch      = 1'b1;
            dec.link        = (rt == RT_BGEZAL);
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_J, OP_JAL: begin
        dec.alu_control = ALU_AND;
        dec.jump        = 1'b1;
        dec.link        = (op == OP_JAL);
      end
      default: dec.illegal = 1'b1;
    endcase
    // Undecodable words carry only the illegal flag.
    if (dec.illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  assign dec_o = dec;

endmodule

// File: rtl/mips_cpu_alu_decode.sv
// Decode stage: combinational decode feeding a two-entry skid buffer so that
// in_ready comes only from state flops and never from out_ready.
module mips_cpu_alu_decode
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] instr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  alu_control,
  output logic [4:0]  alu_as,
  output logic [31:0] imm_ext,
  output logic        alu_src_imm,
  output logic        a_zero,
  output logic        branch,
  output logic        jump,
  output logic        link,
  output logic        illegal
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e   state_q, state_d;
  decoded_t dec;
  decoded_t head_q, head_d;
  decoded_t skid_q, skid_d;
  logic     in_fire;
  logic     out_fire;

  mips_cpu_alu_decode_comb u_comb (
    .instr_i (instr),
    .dec_o   (dec)
  );

  assign in_ready  = (state_q != StTwo);
  assign out_valid = (state_q != StEmpty);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            head_d  = dec;
            state_d = StOne;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            head_d = dec;
          end else if (in_fire) begin
            skid_d  = dec;
            state_d = StTwo;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (out_fire) begin
            head_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign alu_control = head_q.alu_control;
  assign alu_as      = head_q.alu_as;
  assign imm_ext     = head_q.imm_ext;
  assign alu_src_imm = head_q.alu_src_imm;
  assign a_zero      = head_q.a_zero;
  assign branch      = head_q.branch;
  assign jump        = head_q.jump;
  assign link        = head_q.link;
  assign illegal     = head_q.illegal;

endmodule

// File: tb/tb_mips_cpu_alu_decode.sv
// Directed bench for mips_cpu_alu_decode with a scoreboard of expected decoded entries.
module tb_mips_cpu_alu_decode;

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [4:0]  code;
    logic [4:0]  as;
    logic [31:0] imm;
    bit          ci;
    bit          src;
    bit          az;
    bit          br;
    bit          j;
    bit          l;
    bit          il;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] instr;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  alu_control;
  logic [4:0]  alu_as;
  logic [31:0] imm_ext;
  logic        alu_src_imm;
  logic        a_zero;
  logic        branch;
  logic        jump;
  logic        link;
  logic        illegal;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  exp_t stream[$];

  mips_cpu_alu_decode dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .instr       (instr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_control (alu_control),
    .alu_as      (alu_as),
    .imm_ext     (imm_ext),
    .alu_src_imm (alu_src_imm),
    .a_zero      (a_zero),
    .branch      (branch),
    .jump        (jump),
    .link        (link),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(string n, logic [31:0] ins, logic [4:0] code, logic [4:0] as,
                              logic [31:0] imm, bit ci, bit src, bit az, bit br, bit j, bit l,
                              bit il);
    exp_t e;
    e.name = n; e.ins = ins; e.code = code; e.as = as; e.imm = imm; e.ci = ci;
    e.src = src; e.az = az; e.br = br; e.j = j; e.l = l; e.il = il;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cmp_head(input exp_t e);
    chk({e.name, ".alu_control"}, 32'(alu_control), 32'(e.code));
    chk({e.name, ".alu_as"}, 32'(alu_as), 32'(e.as));
    if (e.ci) chk({e.name, ".imm_ext"}, imm_ext, e.imm);
    chk({e.name, ".alu_src_imm"}, 32'(alu_src_imm), 32'(e.src));
    chk({e.name, ".a_zero"}, 32'(a_zero), 32'(e.az));
    chk({e.name, ".branch"}, 32'(branch), 32'(e.br));
    chk({e.name, ".jump"}, 32'(jump), 32'(e.j));
    chk({e.name, ".link"}, 32'(link), 32'(e.l));
    chk({e.name, ".illegal"}, 32'(illegal), 32'(e.il));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".fields"}, {7'd0, alu_control, alu_as, alu_src_imm, a_zero, branch, jump, link,
                           illegal, 8'd0}, 32'd0);
    chk({tag, ".imm_ext"}, imm_ext, 32'd0);
  endtask

  // Check handshake and head against the model, then advance one clock.
  task automatic tick(input exp_t e, output bit fired_in);
    bit fi;
    bit fo;
    fi = in_valid && !flush && (q.size() < 2);
    fo = out_ready && !flush && (q.size() > 0);
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) cmp_head(q[0]);
    if (fo) void'(q.pop_front());
    if (fi) q.push_back(e);
    if (flush) q.delete();
    fired_in = fi;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit f;
    exp_t none;
    none = mk("none", 32'h0, 5'd0, 5'd0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6 && q.size() > 0; i++) tick(none, f);
    tick(none, f);
  endtask

  initial begin
    exp_t e_addu, e_subu, e_xor, e_lui, e_ori, e_andi, e_ill, e_none;
    bit   f;

    e_addu = mk("addu", 32'h02328021, 5'b00010, 5'd0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    e_subu = mk("subu", 32'h02328023, 5'b00110, 5'd0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    e_xor  = mk("xor", 32'h02328026, 5'b01101, 5'd0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    e_lui  = mk("lui", 32'h3C011234, 5'b00001, 5'd8, 32'h12340000, 1, 1, 1, 0, 0, 0, 0);
    e_ori  = mk("ori", 32'h3421FFFF, 5'b00001, 5'd31, 32'h0000FFFF, 1, 1, 0, 0, 0, 0, 0);
    e_andi = mk("andi", 32'h30428001, 5'b00000, 5'd0, 32'h00008001, 1, 1, 0, 0, 0, 0, 0);
    e_ill  = mk("illegal", 32'hFC000000, 5'b00000, 5'd0, 32'h0, 0, 0, 0, 0, 0, 0, 1);
    e_none = mk("none", 32'h0, 5'd0, 5'd0, 32'h0, 0, 0, 0, 0, 0, 0, 0);

    stream.push_back(e_addu);
    stream.push_back(e_lui);
    stream.push_back(e_ori);
    stream.push_back(mk("bgezal", 32'h0411FFFE, 5'b11011, 5'd31, 32'hFFFFFFFE, 1, 0, 0, 1, 0, 1,
                        0));
    stream.push_back(mk("sra", 32'h00021A83, 5'b01010, 5'd10, 32'h0, 0, 0, 0, 0, 0, 0, 0));
    stream.push_back(mk("j", 32'h08000010, 5'b00000, 5'd0, 32'h0, 0, 0, 0, 0, 1, 0, 0));
    stream.push_back(mk("jalr", 32'h0060F809, 5'b00010, 5'd0, 32'h0, 0, 0, 0, 0, 1, 1, 0));
    stream.push_back(mk("beq", 32'h1022FFFF, 5'b00110, 5'd31, 32'hFFFFFFFF, 1, 0, 0, 1, 0, 0, 0));
    stream.push_back(e_andi);
    stream.push_back(mk("lw", 32'h8C41FFFC, 5'b00010, 5'd31, 32'hFFFFFFFC, 1, 1, 0, 0, 0, 0, 0));
    stream.push_back(mk("bltz", 32'h04000003, 5'b11111, 5'd0, 32'h00000003, 1, 0, 0, 1, 0, 0, 0));
    stream.push_back(mk("slti", 32'h2822FF00, 5'b01000, 5'd28, 32'hFFFFFF00, 1, 1, 0, 0, 0, 0, 0));
    stream.push_back(mk("badfn", 32'h0232803F, 5'b00000, 5'd0, 32'h0, 0, 0, 0, 0, 0, 0, 1));

    rst_n = 1'b0; flush = 1'b0; instr = 32'h0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back stream with out_ready held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    foreach (stream[i]) begin
      instr = stream[i].ins;
      tick(stream[i], f);
    end
    drain();

    // Backpressure: fill both entries, third word must wait.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr = e_addu.ins; tick(e_addu, f);
    instr = e_subu.ins; tick(e_subu, f);
    chk("bp.in_ready_low", 32'(in_ready), 32'd0);
    instr = e_xor.ins;  tick(e_xor, f);
    tick(e_xor, f);
    out_ready = 1'b1;
    for (int i = 0; i < 8 && in_valid; i++) begin
      tick(e_xor, f);
      if (f) in_valid = 1'b0;
    end
    drain();

    // Flush from TWO with a simultaneous input.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr = e_lui.ins; tick(e_lui, f);
    instr = e_ori.ins; tick(e_ori, f);
    flush = 1'b1; instr = e_andi.ins; tick(e_andi, f);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2.out_valid", 32'(out_valid), 32'd0);
    chk("flush2.in_ready", 32'(in_ready), 32'd1);
    tick(e_none, f);

    // Flush from ONE must override an acceptable input.
    in_valid = 1'b1;
    instr = e_lui.ins; tick(e_lui, f);
    flush = 1'b1; instr = e_andi.ins; tick(e_andi, f);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1.out_valid", 32'(out_valid), 32'd0);
    tick(e_none, f);

    // Illegal word still flows through.
    in_valid = 1'b1; out_ready = 1'b1;
    instr = e_ill.ins; tick(e_ill, f);
    drain();

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr = e_lui.ins; tick(e_lui, f);
    instr = e_ori.ins; tick(e_ori, f);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async_reset");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b1; out_ready = 1'b1;
    instr = e_subu.ins; tick(e_subu, f);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_cpu_alu_decode.md
# mips_cpu_alu_decode

Instruction-to-ALU-control decode stage for the MIPS CPU. It accepts fetched 32-bit instructions over a valid/ready handshake, decodes each into the 5-bit ALU operation code, shift amount, extended immediate and branch/jump qualifiers the ALU and branch logic consume, and presents them registered to the execute stage. A two-entry skid buffer keeps `in_ready` a pure register output, so no combinational path runs from `out_ready` back to fetch.

## Interface
- No parameters; all widths fixed by the MIPS32 ISA.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous; discards all buffered entries.
- `instr`  in  32  instruction word.
- `in_valid`  in  1  `instr` is valid.
- `in_ready`  out  1  stage can accept; registered.
- `out_valid`  out  1  decoded entry is presented.
- `out_ready`  in  1  execute stage accepts the entry.
- `alu_control`  out  5  ALU operation code.
- `alu_as`  out  5  shift amount, `instr[10:6]`.
- `imm_ext`  out  32  extended immediate.
- `alu_src_imm`  out  1  ALU operand b = `imm_ext`, not rt.
- `a_zero`  out  1  ALU operand a forced to 0 (LUI).
- `branch`  out  1  conditional branch; taken when ALU `zero` = 1.
- `jump`  out  1  J/JAL/JR/JALR.
- `link`  out  1  writes return address (JAL, JALR, BLTZAL, BGEZAL).
- `illegal`  out  1  opcode/funct not decoded.

## Operation
- R-type (op 0), funct to code: 24 AND 00000, 25 OR 00001, 21 ADDU 00010, 23 SUBU 00110, 2B SLTU 00111, 2A SLT 01000, 00 SLL 01001, 03 SRA 01010, 02 SRL 01011, 27 NOR 01100, 26 XOR 01101, 04 SLLV 01110, 07 SRAV 01111, 06 SRLV 10000. JR 08, JALR 09: code 00010, `jump`=1, `link`=JALR.
- I-type, sign-extended: ADDIU 09 → 00010, SLTI 0A → 01000, SLTIU 0B → 00111, loads 20/21/23/24/25 and stores 28/29/2B → 00010.
- I-type, zero-extended: ANDI 0C → 00000, ORI 0D → 00001, XORI 0E → 01101.
- LUI 0F: `imm_ext` = {imm, 16'h0}, code 00001, `a_zero`=1.
- All I-type ops: `alu_src_imm`=1.
- Branches, `imm_ext` sign-extended, `alu_src_imm`=0:
  - BEQ 04 → 00110
  - BNE 05 → 11000
  - BLEZ 06 → 11010
  - BGTZ 07 → 11001
- REGIMM (op 01), by rt:
  - 00000 BLTZ, 10000 BLTZAL → 11111
  - 00001 BGEZ, 10001 BGEZAL → 11011
  - `link`=1 for the AL forms.
- J 02, JAL 03: code 00000, `jump`=1, `link`=JAL.
- Anything else: `illegal`=1, code 00000, all other qualifiers 0; the entry still flows through the handshake.
- Decode is combinational on the `instr` being written; buffers store decoded fields, not raw instructions.

## Timing
- Latency: accepted at edge N → `out_valid` from edge N (after N).
- Transfers: input when `in_valid && in_ready`; output when `out_valid && out_ready`.
- Buffer FSM:
  - EMPTY: `in_ready`=1, `out_valid`=0.
  - ONE: `in_ready`=1, `out_valid`=1.
  - TWO: `in_ready`=0, `out_valid`=1.
- Transitions:
  - EMPTY → ONE on input.
  - ONE → TWO on input without output.
  - ONE → EMPTY on output without input.
  - ONE stays ONE on simultaneous input and output.
  - TWO → ONE on output.
- Order is FIFO; the head entry always drives the outputs, and the skid entry moves to the head on output.
- Output fields hold stable while `out_valid && !out_ready`.
- `flush` → EMPTY next edge and overrides a simultaneous input; output fields are don't-care after flush.
- Reset, including mid-transfer: state EMPTY, `in_ready`=1, `out_valid`=0, all decoded outputs 0.
- `in_ready` must not depend combinationally on `out_ready`.

## Structure
- Shared package `mips_cpu_pkg`: ALU opcode localparams (ALU_AND … ALU_BLTZ, shared with the ALU), opcode/funct/REGIMM-rt constants, and a packed `decoded_t` struct (fields above).
- Sub-module `mips_cpu_alu_decode_comb`: pure `instr` → `decoded_t`. The top level holds only the skid FSM and two `decoded_t` registers.

## Test plan
- Reset, then `instr`=0x02328021 (ADDU) with `out_ready`=1 → one edge later: `out_valid`=1, `alu_control`=00010, `alu_src_imm`=0, `illegal`=0.
- `instr`=0x3C011234 (LUI) → `imm_ext`=0x12340000, code 00001, `a_zero`=1; `instr`=0x3421FFFF (ORI) → `imm_ext`=0x0000FFFF.
- `instr`=0x0411FFFE (BGEZAL) → code 11011, `branch`=1, `link`=1, `imm_ext`=0xFFFFFFFE; `instr`=0x00021A83 (SRA 10) → code 01010, `alu_as`=10.
- Backpressure with `out_ready`=0, inputs ADDU, SUBU, XOR:
  - ADDU accepted; SUBU accepted and `in_ready` drops the next edge; XOR held.
  - Raising `out_ready` → ADDU, SUBU, XOR emerge in order, none lost or duplicated.
- `flush` in state TWO together with `in_valid` → next edge `out_valid`=0, `in_ready`=1, incoming word dropped; `instr`=0xFC000000 → `illegal`=1.
- `rst_n` asserted low mid-stall with `out_valid`=1 → `out_valid` and all outputs 0 immediately, without waiting for a clock edge.
